// File: rtl/dr_pfreq_queue.sv
// dr_pfreq_queue
// Prefetch-request staging queue sitting in front of the directory bank's
// pfreq input. It never back-pressures L2. It filters duplicate line
// addresses. It cancels queued prefetches that a demand request has
// overtaken. On overflow it drops the oldest entry. Dropped prefetches are
// never acked.
//
// Storage is a shift-compacted register file: valid entries always occupy
// slots [0 .. occupancy-1], and slot 0 is the head. Each cycle the surviving
// entries (after pop and cancel) are packed down in arrival order. The new
// entry, if any, is then appended.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   in_valid        prefetch request from L2
//   in_retry        retry to L2 (always 0)
//   in_addr/in_data line address / opaque payload of the incoming prefetch
//   out_valid       head entry presented to the directory bank
//   out_retry       retry from the directory bank
//   out_addr/data   head entry contents (registered)
//   cancel_valid    a demand request was accepted by the directory this cycle
//   cancel_addr     line address of that demand request
//   occupancy       number of valid entries
//   drop_cnt        saturating count of overflow and duplicate drops
module dr_pfreq_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 44,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_retry,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_retry,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     cancel_valid,
  input  logic [ADDR_W-1:0]        cancel_addr,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_reg  [DEPTH];
  logic [DATA_W-1:0] data_reg  [DEPTH];
  logic [ADDR_W-1:0] addr_cmp  [DEPTH];
  logic [DATA_W-1:0] data_cmp  [DEPTH];
  logic [ADDR_W-1:0] addr_next [DEPTH];
  logic [DATA_W-1:0] data_next [DEPTH];

  logic [OCC_W-1:0]  occ_reg, occ_next, kept_cnt;
  logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;

  logic [DEPTH-1:0]  valid_vec, cancel_hit, keep_vec, dup_vec;
  logic              pop, dup_hit, cancel_in, push_ok, overflow, drop_inc;

  assign pop = (occ_reg != '0) && !out_retry;

  // Per-slot survival and match flags. A slot survives the cycle if it is
  // valid, not the popped head, and not hit by the demand cancel.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    localparam bit IS_HEAD = (gi == 0);
    assign valid_vec[gi]  = OCC_W'(gi) < occ_reg;
    assign cancel_hit[gi] = cancel_valid && (addr_reg[gi] == cancel_addr);
    assign keep_vec[gi]   = valid_vec[gi] && !cancel_hit[gi] && !(pop && IS_HEAD);
    // Duplicates are judged only against entries that survive pop and cancel.
    assign dup_vec[gi]    = keep_vec[gi] && (addr_reg[gi] == in_addr);
  end

  assign dup_hit   = |dup_vec;
  // A push for the very line a demand just took is useless; discard it silently.
  assign cancel_in = cancel_valid && (in_addr == cancel_addr);
  assign push_ok   = in_valid && !dup_hit && !cancel_in;

  // Pack surviving entries down to slot 0 while keeping their order.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_cmp[i] = '0;
      data_cmp[i] = '0;
    end
    kept_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep_vec[i]) begin
        addr_cmp[kept_cnt[PTR_W-1:0]] = addr_reg[i];
        data_cmp[kept_cnt[PTR_W-1:0]] = data_reg[i];
        kept_cnt = kept_cnt + OCC_W'(1);
      end
    end
  end

  // A full queue can only survive to here when nothing popped or cancelled.
  assign overflow = push_ok && (kept_cnt == OCC_W'(DEPTH));

  always_comb begin
    addr_next = addr_cmp;
    data_next = data_cmp;
    occ_next  = kept_cnt;
    if (overflow) begin
      // Drop the oldest entry, even if it is presented under retry.
      for (int i = 0; i < DEPTH - 1; i++) begin
        addr_next[i] = addr_cmp[i+1];
        data_next[i] = data_cmp[i+1];
      end
      addr_next[DEPTH-1] = in_addr;
      data_next[DEPTH-1] = in_data;
    end else if (push_ok) begin
      addr_next[kept_cnt[PTR_W-1:0]] = in_addr;
      data_next[kept_cnt[PTR_W-1:0]] = in_data;
      occ_next = kept_cnt + OCC_W'(1);
    end
  end

  assign drop_inc      = (in_valid && dup_hit && !cancel_in) || overflow;
  assign drop_cnt_next = (drop_inc && (drop_cnt_reg != '1)) ?
                         drop_cnt_reg + CNT_W'(1) : drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_reg      <= '0;
      drop_cnt_reg <= '0;
    end else begin
      occ_reg      <= occ_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Entry contents need no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    addr_reg <= addr_next;
    data_reg <= data_next;
  end

  assign in_retry  = 1'b0;
  assign out_valid = (occ_reg != '0);
  assign out_addr  = addr_reg[0];
  assign out_data  = data_reg[0];
  assign occupancy = occ_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_dr_pfreq_queue.sv
module tb_dr_pfreq_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 44;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_retry;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_retry;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              cancel_valid;
  logic [ADDR_W-1:0] cancel_addr;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dr_pfreq_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_retry(in_retry), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_retry(out_retry), .out_addr(out_addr), .out_data(out_data),
    .cancel_valid(cancel_valid), .cancel_addr(cancel_addr),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  // Reference model: an ordered list of pending prefetches plus a drop count.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t mq[$];
  int   m_drop = 0;

  function automatic void model_step(input logic r, input logic iv,
                                     input logic [ADDR_W-1:0] ia, input logic [DATA_W-1:0] id,
                                     input logic rt, input logic cv, input logic [ADDR_W-1:0] ca);
    bit   found;
    ent_t e;
    if (r) begin
      mq.delete();
      m_drop = 0;
      return;
    end
    if (mq.size() > 0 && !rt) void'(mq.pop_front());
    if (cv) begin
      for (int k = mq.size() - 1; k >= 0; k--)
        if (mq[k].a == ca) mq.delete(k);
    end
    if (iv) begin
      found = 0;
      foreach (mq[k]) if (mq[k].a == ia) found = 1;
      if (cv && ia == ca) begin
        // discarded, not counted
      end else if (found) begin
        if (m_drop < CNT_MAX) m_drop++;
      end else begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          if (m_drop < CNT_MAX) m_drop++;
        end
        e.a = ia;
        e.d = id;
        mq.push_back(e);
      end
    end
  endfunction

  // Drive one cycle of inputs, advance through the edge, update the model and
  // return 1 time unit after the edge, where outputs are stable.
  task automatic drive_cycle(input logic r, input logic iv,
                             input logic [ADDR_W-1:0] ia, input logic [DATA_W-1:0] id,
                             input logic rt, input logic cv, input logic [ADDR_W-1:0] ca);
    reset = r; in_valid = iv; in_addr = ia; in_data = id;
    out_retry = rt; cancel_valid = cv; cancel_addr = ca;
    @(posedge clk);
    model_step(r, iv, ia, id, rt, cv, ca);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic rt);
    drive_cycle(1'b0, 1'b1, a, 32'hA000_0000 | a[31:0], rt, 1'b0, '0);
  endtask

  task automatic idle(input logic rt);
    drive_cycle(1'b0, 1'b0, '0, '0, rt, 1'b0, '0);
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 44'h123, 32'h1, 1'b0, 1'b0, '0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    n_checks++; if (occupancy !== 0) begin n_fail++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
    n_checks++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
    n_checks++; if (in_retry !== 1'b0) begin n_fail++; $display("FAIL reset_in_retry got=%0b want=0", in_retry); end
    $display("test_reset done");
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] exp_a;
    do_reset();
    for (int k = 1; k <= 5; k++) push(44'(k * 16), 1'b1);
    n_checks++; if (occupancy !== 4) begin n_fail++; $display("FAIL ovf_occupancy got=%0d want=4", occupancy); end
    n_checks++; if (out_addr !== 44'h20) begin n_fail++; $display("FAIL ovf_head got=%h want=20", out_addr); end
    n_checks++; if (drop_cnt !== 1) begin n_fail++; $display("FAIL ovf_drop_cnt got=%0d want=1", drop_cnt); end
    for (int k = 0; k < 4; k++) begin
      exp_a = 44'(32 + 16 * k);
      n_checks++;
      if (out_valid !== 1'b1 || out_addr !== exp_a) begin
        n_fail++; $display("FAIL ovf_drain%0d got=%0b/%h want=1/%h", k, out_valid, out_addr, exp_a);
      end
      idle(1'b0);
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got=%0b want=0", out_valid); end
    $display("test_overflow done");
  endtask

  task automatic test_duplicate();
    int xfers;
    do_reset();
    push(44'h10, 1'b1);
    push(44'h10, 1'b1);
    n_checks++; if (occupancy !== 1) begin n_fail++; $display("FAIL dup_occupancy got=%0d want=1", occupancy); end
    n_checks++; if (drop_cnt !== 1) begin n_fail++; $display("FAIL dup_drop_cnt got=%0d want=1", drop_cnt); end
    xfers = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid === 1'b1 && out_addr === 44'h10) xfers++;
      idle(1'b0);
    end
    n_checks++; if (xfers !== 1) begin n_fail++; $display("FAIL dup_transfers got=%0d want=1", xfers); end
    $display("test_duplicate done");
  endtask

  task automatic test_cancel();
    do_reset();
    push(44'h10, 1'b1); push(44'h20, 1'b1); push(44'h30, 1'b1);
    drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 44'h20);
    n_checks++; if (occupancy !== 2) begin n_fail++; $display("FAIL cancel_occupancy got=%0d want=2", occupancy); end
    n_checks++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL cancel_drop_cnt got=%0d want=0", drop_cnt); end
    n_checks++; if (out_addr !== 44'h10) begin n_fail++; $display("FAIL cancel_first got=%h want=10", out_addr); end
    idle(1'b0);
    n_checks++; if (out_addr !== 44'h30) begin n_fail++; $display("FAIL cancel_second got=%h want=30", out_addr); end
    $display("test_cancel done");
  endtask

  task automatic test_full_pop_push_cancel();
    logic [ADDR_W-1:0] exp_a [4];
    exp_a[0] = 44'h20; exp_a[1] = 44'h30; exp_a[2] = 44'h40; exp_a[3] = 44'h99;
    do_reset();
    for (int k = 1; k <= 4; k++) push(44'(k * 16), 1'b1);
    drive_cycle(1'b0, 1'b1, 44'h99, 32'h99, 1'b0, 1'b1, 44'h777);
    n_checks++; if (occupancy !== 4) begin n_fail++; $display("FAIL fppc_occupancy got=%0d want=4", occupancy); end
    n_checks++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL fppc_drop_cnt got=%0d want=0", drop_cnt); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_addr !== exp_a[k]) begin
        n_fail++; $display("FAIL fppc_drain%0d got=%0b/%h want=1/%h", k, out_valid, out_addr, exp_a[k]);
      end
      idle(1'b0);
    end
    $display("test_full_pop_push_cancel done");
  endtask

  task automatic test_pop_cancel_same();
    do_reset();
    push(44'h10, 1'b1); push(44'h20, 1'b1);
    n_checks++; if (out_addr !== 44'h10) begin n_fail++; $display("FAIL pcs_head got=%h want=10", out_addr); end
    drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 44'h10);
    n_checks++; if (occupancy !== 1) begin n_fail++; $display("FAIL pcs_occupancy got=%0d want=1", occupancy); end
    n_checks++; if (out_addr !== 44'h20) begin n_fail++; $display("FAIL pcs_next got=%h want=20", out_addr); end
    n_checks++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL pcs_drop_cnt got=%0d want=0", drop_cnt); end
    $display("test_pop_cancel_same done");
  endtask

  task automatic test_reset_midop();
    do_reset();
    push(44'h10, 1'b1);
    for (int k = 0; k < 5; k++) push(44'h10, 1'b1);
    push(44'h20, 1'b1); push(44'h30, 1'b1);
    n_checks++; if (occupancy !== 3 || drop_cnt !== 5) begin
      n_fail++; $display("FAIL midop_pre got=%0d/%0d want=3/5", occupancy, drop_cnt);
    end
    drive_cycle(1'b1, 1'b1, 44'h40, 32'h40, 1'b0, 1'b0, '0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_out_valid got=%0b want=0", out_valid); end
    n_checks++; if (occupancy !== 0) begin n_fail++; $display("FAIL midop_occupancy got=%0d want=0", occupancy); end
    n_checks++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL midop_drop_cnt got=%0d want=0", drop_cnt); end
    push(44'h50, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_addr !== 44'h50 || occupancy !== 1) begin
      n_fail++; $display("FAIL midop_first_push got=%0b/%h/%0d want=1/50/1", out_valid, out_addr, occupancy);
    end
    $display("test_reset_midop done");
  endtask

  task automatic test_saturation();
    do_reset();
    push(44'h10, 1'b1);
    for (int k = 0; k < CNT_MAX + 5; k++) push(44'h10, 1'b1);
    n_checks++; if (drop_cnt !== CNT_W'(CNT_MAX)) begin
      n_fail++; $display("FAIL sat_drop_cnt got=%0d want=%0d", drop_cnt, CNT_MAX);
    end
    $display("test_saturation done");
  endtask

  task automatic test_random();
    logic              r, iv, rt, cv;
    logic [ADDR_W-1:0] ia, ca;
    logic [DATA_W-1:0] id;
    int                cyc_fail;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      r  = ($urandom_range(0, 199) == 0);
      iv = ($urandom_range(0, 9) < 7);
      rt = ($urandom_range(0, 1) == 1);
      cv = ($urandom_range(0, 9) < 3);
      ia = 44'($urandom_range(0, 7) * 16);
      ca = 44'($urandom_range(0, 7) * 16);
      id = $urandom;
      drive_cycle(r, iv, ia, id, rt, cv, ca);
      cyc_fail = 0;
      n_checks++;
      if (out_valid !== (mq.size() != 0)) cyc_fail = 1;
      if (occupancy !== mq.size()) cyc_fail = 1;
      if (drop_cnt !== CNT_W'(m_drop)) cyc_fail = 1;
      if (mq.size() != 0 && (out_addr !== mq[0].a || out_data !== mq[0].d)) cyc_fail = 1;
      if (cyc_fail != 0) begin
        n_fail++;
        $display("FAIL random_cyc%0d got v=%0b occ=%0d drop=%0d addr=%h want v=%0b occ=%0d drop=%0d addr=%h",
                 c, out_valid, occupancy, drop_cnt, out_addr, (mq.size() != 0), mq.size(), m_drop,
                 (mq.size() != 0) ? mq[0].a : 44'h0);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    out_retry = 1'b1; cancel_valid = 1'b0; cancel_addr = '0;
    @(negedge clk);
    test_reset();
    test_overflow();
    test_duplicate();
    test_cancel();
    test_full_pop_push_cancel();
    test_pop_cancel_same();
    test_reset_midop();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dr_pfreq_queue.md
Name: dr_pfreq_queue

Overview:
Prefetch-request staging queue directly upstream of the directory bank's l2todr_pfreq input. It absorbs L2 prefetch requests without back-pressure: when full it drops the oldest entry, filters duplicates by line address, and cancels queued prefetches that a demand request has overtaken. Dropped prefetches are never acked, matching the pfreq contract.

Parameters:
DEPTH, 8, number of queue entries; legal values are 4, 8 and 16.
ADDR_W, 44, line-address width (64-byte line, so byte offset is excluded).
DATA_W, 32, remaining request payload (node id, request type, etc.), carried opaquely.
CNT_W, 16, width of the saturating drop counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  prefetch request from L2 (l2todr_pfreq side)
in_retry  out  1  retry to L2; constant 0
in_addr  in  ADDR_W  line address of the incoming prefetch
in_data  in  DATA_W  remaining payload of the incoming prefetch
out_valid  out  1  prefetch presented to the directory bank
out_retry  in  1  retry from the directory bank
out_addr  out  ADDR_W  head entry line address
out_data  out  DATA_W  head entry payload
cancel_valid  in  1  a demand request was accepted by the directory this cycle
cancel_addr  in  ADDR_W  line address of that demand request
occupancy  out  $clog2(DEPTH)+1  current number of valid entries
drop_cnt  out  CNT_W  saturating count of overflow drops plus duplicate drops

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high on reset.
- Handshake: valid/retry. A transfer occurs in a cycle where valid=1 and retry=0.
  - in_retry is tied to 0, including during reset; a push during reset is discarded.
- Reset values: out_valid=0, occupancy=0, drop_cnt=0, all entries invalid. out_addr and out_data are don't-care while out_valid=0.
- Ordering: entries are strictly FIFO by arrival, and removal of middle entries preserves the order of the rest.
  - out_* always shows the oldest valid entry; out_valid = (occupancy != 0).
  - out_* is driven from registers only, with no combinational path from in_* or cancel_*.
- Latency: a push into an empty queue at cycle N appears on out_valid at N+1. There is no bypass.
- Pop: out_valid & ~out_retry removes the head at the clock edge.
- Cancel: when cancel_valid=1, every remaining entry (after this cycle's pop) whose addr == cancel_addr is removed at the edge.
  - Cancelled entries are not counted in drop_cnt.
  - A head that transfers in the same cycle it is cancelled counts as sent.
- Duplicate filter: a push whose in_addr matches any entry remaining after pop and cancel is discarded, and drop_cnt increments.
  - A push whose in_addr == cancel_addr in the same cycle is also discarded, but not counted.
- Overflow: if a non-discarded push arrives and the post-pop/cancel occupancy == DEPTH, the oldest entry is dropped and the new entry is appended. drop_cnt increments.
  - The oldest entry is dropped even if it is currently presented with out_retry=1.
  - out_* may change while out_retry=1; the directory bank accepts this for pfreq.
- Push, pop and cancel in the same cycle: evaluate in the order pop, then cancel, then duplicate check, then overflow check, then append. occupancy reflects the net result.
- drop_cnt saturates at all-ones; it does not wrap.
- Occupancy stays within [0, DEPTH]. It never underflows on a pop of an empty queue (out_valid=0 means no pop).
- Reset asserted mid-operation clears all state in the next cycle regardless of other inputs.
- Implementation target is 120-400 lines of RTL. Shift-compaction and valid-mask ring buffer are both acceptable provided the ordering above holds.

Test Plan:
- DEPTH=4, out_retry=1, push A=0x10, B=0x20, C=0x30, D=0x40, E=0x50 on consecutive cycles -> occupancy 4, out_addr=0x20, drop_cnt=1. Then release out_retry -> outputs 0x20, 0x30, 0x40, 0x50 on 4 consecutive cycles.
- Push 0x10, then push 0x10 again while the first is still queued -> occupancy=1, drop_cnt=1, exactly one transfer of 0x10.
- Queue holds 0x10, 0x20, 0x30 with out_retry=1; cancel_valid with cancel_addr=0x20 -> occupancy=2, out order 0x10 then 0x30, drop_cnt unchanged.
- Full queue, in the same cycle: pop head, push new 0x99, cancel_addr = an unrelated address -> no overflow drop, occupancy stays 4, drop_cnt unchanged, 0x99 last out.
- Head 0x10 transfers (out_retry=0) in the same cycle cancel_addr=0x10 -> exactly one transfer counted, occupancy decrements by 1.
- With 3 entries queued and drop_cnt=5, assert reset for 1 cycle during a push -> next cycle out_valid=0, occupancy=0, drop_cnt=0; the first push after reset appears one cycle later.
